// File: rtl/cu_pkg.sv
// Shared types, opcode map and instruction field slicing for the cu_seq control unit.
package cu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_ILLEGAL,
        CL_HALT,
        CL_LOAD,
        CL_STORE
    } op_class_t;

    // Codes for the 4-bit opcode space; wider spaces keep HALT/LOAD/STORE as the top three codes.
    localparam int OP_NOP   = 0;
    localparam int ALU_MIN  = 1;
    localparam int ALU_MAX  = 9;
    localparam int OP_HALT  = 13;
    localparam int OP_LOAD  = 14;
    localparam int OP_STORE = 15;

    localparam int FIELD_MAXW = 64;
    typedef logic [FIELD_MAXW-1:0] field_t;

    function automatic field_t field_get(field_t word, int lsb, int width);
        field_t mask;
        mask = (field_t'(1) << width) - field_t'(1);
        return (word >> lsb) & mask;
    endfunction

    function automatic field_t f_opcode(field_t ir, int opw, int regw);
        return field_get(ir, 3 * regw, opw);
    endfunction

    function automatic field_t f_a(field_t ir, int regw);
        return field_get(ir, 2 * regw, regw);
    endfunction

    function automatic field_t f_b(field_t ir, int regw);
        return field_get(ir, regw, regw);
    endfunction

    function automatic field_t f_dest(field_t ir, int regw);
        return field_get(ir, 0, regw);
    endfunction

    // The memory address sits directly under the opcode; leftover bits above dest are reserved.
    function automatic field_t f_adrr(field_t ir, int regw, int addrw);
        return field_get(ir, 3 * regw - addrw, addrw);
    endfunction

    function automatic op_class_t classify(int op, int opw);
        int top_shift;
        top_shift = ((1 << opw) - 1) - OP_STORE;
        if (op == OP_NOP) begin
            return CL_NOP;
        end
        if (op >= ALU_MIN && op <= ALU_MAX) begin
            return CL_ALU;
        end
        if (op == OP_HALT + top_shift) begin
            return CL_HALT;
        end
        if (op == OP_LOAD + top_shift) begin
            return CL_LOAD;
        end
        if (op == OP_STORE + top_shift) begin
            return CL_STORE;
        end
        return CL_ILLEGAL;
    endfunction

endpackage

// File: rtl/cu_seq_if.sv
// Instruction-fetch handshake plus register-file, ALU and data-memory control bundle.
interface cu_seq_if #(
    parameter int OPW   = 4,
    parameter int REGW  = 3,
    parameter int ADDRW = 4,
    parameter int PCW   = 8
);
    localparam int INSTW = OPW + 3 * REGW;

    logic             imem_req;
    logic [PCW-1:0]   imem_addr;
    logic             imem_ack;
    logic [INSTW-1:0] imem_rdata;
    logic [REGW-1:0]  rf_ra;
    logic [REGW-1:0]  rf_rb;
    logic [REGW-1:0]  rf_wa;
    logic             rf_we;
    logic             rf_wsel;
    logic [OPW-1:0]   alu_op;
    logic [ADDRW-1:0] dm_addr;
    logic             dm_re;
    logic             dm_we;
    logic             halted;
    logic             illegal;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output rf_ra, rf_rb, rf_wa, rf_we, rf_wsel,
        output alu_op, dm_addr, dm_re, dm_we,
        output halted, illegal
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  rf_ra, rf_rb, rf_wa, rf_we, rf_wsel,
        input  alu_op, dm_addr, dm_re, dm_we,
        input  halted, illegal
    );

endinterface

// File: rtl/cu_decode.sv
// Combinational split of the instruction register into class and operand fields.
module cu_decode
    import cu_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int REGW  = 3,
    parameter int ADDRW = 4
) (
    input  logic [OPW+3*REGW-1:0] ir_i,
    output op_class_t             cls_o,
    output logic [OPW-1:0]        opcode_o,
    output logic [REGW-1:0]       a_o,
    output logic [REGW-1:0]       b_o,
    output logic [REGW-1:0]       dest_o,
    output logic [ADDRW-1:0]      adrr_o
);

    field_t ir_w;

    assign ir_w     = field_t'(ir_i);
    assign opcode_o = OPW'(f_opcode(ir_w, OPW, REGW));
    assign a_o      = REGW'(f_a(ir_w, REGW));
    assign b_o      = REGW'(f_b(ir_w, REGW));
    assign dest_o   = REGW'(f_dest(ir_w, REGW));
    assign adrr_o   = ADDRW'(f_adrr(ir_w, REGW, ADDRW));
    assign cls_o    = classify(int'(opcode_o), OPW);

endmodule

// File: rtl/cu_seq.sv
// Multi-cycle control unit: fetch over req/ack, then DECODE/EXEC/MEM/WB with Moore outputs.
module cu_seq
    import cu_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int REGW  = 3,
    parameter int ADDRW = 4,
    parameter int PCW   = 8
) (
    input  logic      clk,
    input  logic      rst,
    cu_seq_if.master  bus
);

    localparam int INSTW = OPW + 3 * REGW;

    state_t             state_q, state_d;
    logic [PCW-1:0]     pc_q, pc_d;
    logic [INSTW-1:0]   ir_q, ir_d;

    op_class_t          cls;
    logic [OPW-1:0]     opcode;
    logic [REGW-1:0]    fld_a;
    logic [REGW-1:0]    fld_b;
    logic [REGW-1:0]    fld_dest;
    logic [ADDRW-1:0]   fld_adrr;

    cu_decode #(
        .OPW   (OPW),
        .REGW  (REGW),
        .ADDRW (ADDRW)
    ) u_decode (
        .ir_i     (ir_q),
        .cls_o    (cls),
        .opcode_o (opcode),
        .a_o      (fld_a),
        .b_o      (fld_b),
        .dest_o   (fld_dest),
        .adrr_o   (fld_adrr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // imem_ack only steers the next state; every output is a function of state_q and ir_q.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc_q;
        bus.rf_ra     = '0;
        bus.rf_rb     = '0;
        bus.rf_wa     = '0;
        bus.rf_we     = 1'b0;
        bus.rf_wsel   = 1'b0;
        bus.alu_op    = '0;
        bus.dm_addr   = '0;
        bus.dm_re     = 1'b0;
        bus.dm_we     = 1'b0;
        bus.halted    = 1'b0;
        bus.illegal   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + PCW'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (cls)
                    CL_ALU: begin
                        bus.rf_ra = fld_a;
                        bus.rf_rb = fld_b;
                        state_d   = S_EXEC;
                    end
                    CL_LOAD, CL_STORE: begin
                        bus.rf_ra = fld_dest;
                        state_d   = S_MEM;
                    end
                    CL_HALT: begin
                        state_d = S_HALT;
                    end
                    CL_ILLEGAL: begin
                        bus.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                bus.rf_ra   = fld_a;
                bus.rf_rb   = fld_b;
                bus.rf_we   = 1'b1;
                bus.rf_wa   = fld_dest;
                bus.alu_op  = opcode;
                state_d     = S_FETCH;
            end
            S_MEM: begin
                bus.dm_addr = fld_adrr;
                if (cls == CL_LOAD) begin
                    bus.dm_re = 1'b1;
                    state_d   = S_WB;
                end else begin
                    bus.dm_we = 1'b1;
                    bus.rf_ra = fld_dest;
                    state_d   = S_FETCH;
                end
            end
            S_WB: begin
                bus.rf_we   = 1'b1;
                bus.rf_wa   = fld_dest;
                bus.rf_wsel = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cu_seq.sv
// Directed bench for cu_seq over three configurations, with a cycle-schedule reference model.
module tb_cu_seq;

    localparam int N = 3;
    localparam int OPW_C   [N] = '{4, 4, 5};
    localparam int REGW_C  [N] = '{3, 3, 4};
    localparam int ADDRW_C [N] = '{4, 4, 6};
    localparam int PCW_C   [N] = '{8, 2, 8};

    typedef struct packed {
        logic [31:0] req;
        logic [31:0] addr;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] wa;
        logic [31:0] we;
        logic [31:0] wsel;
        logic [31:0] alu;
        logic [31:0] dma;
        logic [31:0] re;
        logic [31:0] dwe;
        logic [31:0] hlt;
        logic [31:0] ill;
    } obs_t;

    logic        clk;
    logic        rst_v   [N];
    logic        ack_v   [N];
    logic [31:0] rdata_v [N];
    obs_t        obs     [N];

    int   checks;
    int   failures;
    int   cur;
    bit   chk_en;
    int   m_pc;
    bit   m_halt;
    obs_t q [$];

    cu_seq_if #(.OPW(4), .REGW(3), .ADDRW(4), .PCW(8)) if0 ();
    cu_seq_if #(.OPW(4), .REGW(3), .ADDRW(4), .PCW(2)) if1 ();
    cu_seq_if #(.OPW(5), .REGW(4), .ADDRW(6), .PCW(8)) if2 ();

    cu_seq #(.OPW(4), .REGW(3), .ADDRW(4), .PCW(8)) dut0 (.clk(clk), .rst(rst_v[0]), .bus(if0.master));
    cu_seq #(.OPW(4), .REGW(3), .ADDRW(4), .PCW(2)) dut1 (.clk(clk), .rst(rst_v[1]), .bus(if1.master));
    cu_seq #(.OPW(5), .REGW(4), .ADDRW(6), .PCW(8)) dut2 (.clk(clk), .rst(rst_v[2]), .bus(if2.master));

    assign if0.imem_ack   = ack_v[0];
    assign if0.imem_rdata = rdata_v[0][12:0];
    assign if1.imem_ack   = ack_v[1];
    assign if1.imem_rdata = rdata_v[1][12:0];
    assign if2.imem_ack   = ack_v[2];
    assign if2.imem_rdata = rdata_v[2][16:0];

    assign obs[0] = '{req:32'(if0.imem_req), addr:32'(if0.imem_addr), ra:32'(if0.rf_ra), rb:32'(if0.rf_rb), wa:32'(if0.rf_wa), we:32'(if0.rf_we), wsel:32'(if0.rf_wsel), alu:32'(if0.alu_op), dma:32'(if0.dm_addr), re:32'(if0.dm_re), dwe:32'(if0.dm_we), hlt:32'(if0.halted), ill:32'(if0.illegal)};
    assign obs[1] = '{req:32'(if1.imem_req), addr:32'(if1.imem_addr), ra:32'(if1.rf_ra), rb:32'(if1.rf_rb), wa:32'(if1.rf_wa), we:32'(if1.rf_we), wsel:32'(if1.rf_wsel), alu:32'(if1.alu_op), dma:32'(if1.dm_addr), re:32'(if1.dm_re), dwe:32'(if1.dm_we), hlt:32'(if1.halted), ill:32'(if1.illegal)};
    assign obs[2] = '{req:32'(if2.imem_req), addr:32'(if2.imem_addr), ra:32'(if2.rf_ra), rb:32'(if2.rf_rb), wa:32'(if2.rf_wa), we:32'(if2.rf_we), wsel:32'(if2.rf_wsel), alu:32'(if2.alu_op), dma:32'(if2.dm_addr), re:32'(if2.dm_re), dwe:32'(if2.dm_we), hlt:32'(if2.halted), ill:32'(if2.illegal)};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t cfg=%0d got=%0h want=%0h", nm, $time, cur, act, exp);
        end
    endtask

    // Reference: an accepted instruction expands into the list of per-cycle outputs it must produce.
    task automatic accept(logic [31:0] w);
        int   ow  = OPW_C[cur];
        int   rw  = REGW_C[cur];
        int   aw  = ADDRW_C[cur];
        int   op  = int'(w >> (3 * rw)) & ((1 << ow) - 1);
        int   a   = int'(w >> (2 * rw)) & ((1 << rw) - 1);
        int   b   = int'(w >> rw) & ((1 << rw) - 1);
        int   d   = int'(w) & ((1 << rw) - 1);
        int   ad  = int'(w >> (3 * rw - aw)) & ((1 << aw) - 1);
        int   top = (1 << ow) - 1;
        obs_t v;
        m_pc   = (m_pc + 1) % (1 << PCW_C[cur]);
        v      = '0;
        v.addr = m_pc;
        if (op == 0) begin
            q.push_back(v);
        end else if (op <= 9) begin
            v.ra = a; v.rb = b;
            q.push_back(v);
            v.we = 1; v.wa = d; v.alu = op;
            q.push_back(v);
        end else if (op == top) begin
            v.ra = d;
            q.push_back(v);
            v.dma = ad; v.dwe = 1;
            q.push_back(v);
        end else if (op == top - 1) begin
            v.ra = d;
            q.push_back(v);
            v.ra = 0; v.dma = ad; v.re = 1;
            q.push_back(v);
            v.dma = 0; v.re = 0; v.we = 1; v.wa = d; v.wsel = 1;
            q.push_back(v);
        end else if (op == top - 2) begin
            q.push_back(v);
            m_halt = 1'b1;
        end else begin
            v.ill = 1;
            q.push_back(v);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        bit   fetching;
        fetching = (q.size() == 0) && !m_halt;
        e = '0;
        e.addr = m_pc;
        if (q.size() != 0) begin
            e = q.pop_front();
        end else if (m_halt) begin
            e.hlt = 1;
        end else begin
            e.req = 1;
        end
        if (chk_en) begin
            check("m_req",  obs[cur].req,  e.req);
            check("m_addr", obs[cur].addr, e.addr);
            check("m_ra",   obs[cur].ra,   e.ra);
            check("m_rb",   obs[cur].rb,   e.rb);
            check("m_wa",   obs[cur].wa,   e.wa);
            check("m_we",   obs[cur].we,   e.we);
            check("m_wsel", obs[cur].wsel, e.wsel);
            check("m_alu",  obs[cur].alu,  e.alu);
            check("m_dma",  obs[cur].dma,  e.dma);
            check("m_re",   obs[cur].re,   e.re);
            check("m_dwe",  obs[cur].dwe,  e.dwe);
            check("m_hlt",  obs[cur].hlt,  e.hlt);
            check("m_ill",  obs[cur].ill,  e.ill);
        end
        if (rst_v[cur]) begin
            q.delete();
            m_pc   = 0;
            m_halt = 1'b0;
        end else if (fetching && ack_v[cur]) begin
            accept(rdata_v[cur]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(int k, logic [31:0] w, int dly);
        repeat (dly) begin
            check("req_hold", obs[k].req, 1);
            step();
        end
        check("req_at_ack", obs[k].req, 1);
        $display("txn cfg=%0d pc=%0d instr=%0h wait=%0d", k, obs[k].addr, w, dly);
        ack_v[k]   = 1'b1;
        rdata_v[k] = w;
        step();
        ack_v[k] = 1'b0;
    endtask

    task automatic switch_cfg(int k);
        chk_en = 1'b0;
        rst_v[cur] = 1'b1;
        cur = k;
        step();
        step();
        rst_v[k] = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0; cur = 0; chk_en = 1'b0;
        m_pc = 0; m_halt = 1'b0;
        for (int i = 0; i < N; i++) begin
            rst_v[i] = 1'b1; ack_v[i] = 1'b0; rdata_v[i] = '0;
        end
        step();
        chk_en = 1'b1;
        check("rst_req",  obs[0].req, 1);
        check("rst_addr", obs[0].addr, 0);
        check("rst_we",   obs[0].we, 0);
        check("rst_hlt",  obs[0].hlt, 0);
        check("rst_alu",  obs[0].alu, 0);
        rst_v[0] = 1'b0;

        // ALU 0001_001_010_011
        fetch(0, 32'b0001_001_010_011, 0);
        check("alu_dec_ra", obs[0].ra, 1);
        check("alu_dec_rb", obs[0].rb, 2);
        step();
        check("alu_ex_we", obs[0].we, 1);
        check("alu_ex_wa", obs[0].wa, 3);
        check("alu_ex_op", obs[0].alu, 1);
        step();
        check("alu_next_addr", obs[0].addr, 1);

        // LOAD 1110_0100_00_100 after three idle request cycles
        fetch(0, 32'b1110_0100_00_100, 3);
        check("ld_dec_ra", obs[0].ra, 4);
        step();
        check("ld_mem_re", obs[0].re, 1);
        check("ld_mem_addr", obs[0].dma, 4);
        step();
        check("ld_wb_we", obs[0].we, 1);
        check("ld_wb_wa", obs[0].wa, 4);
        check("ld_wb_wsel", obs[0].wsel, 1);
        step();

        // STORE 1111_1100_00_101
        fetch(0, 32'b1111_1100_00_101, 1);
        check("st_dec_ra", obs[0].ra, 5);
        check("st_dec_we", obs[0].we, 0);
        step();
        check("st_mem_ra", obs[0].ra, 5);
        check("st_mem_dwe", obs[0].dwe, 1);
        check("st_mem_addr", obs[0].dma, 12);
        check("st_mem_we", obs[0].we, 0);
        step();

        // illegal 1011, then NOP, then HALT
        fetch(0, 32'b1011_000_000_000, 0);
        check("ill_pulse", obs[0].ill, 1);
        check("ill_we", obs[0].we, 0);
        check("ill_dwe", obs[0].dwe, 0);
        step();
        check("ill_drop", obs[0].ill, 0);
        check("ill_pc", obs[0].addr, 4);
        fetch(0, 32'b0000_000_000_000, 0);
        step();
        check("nop_pc", obs[0].addr, 5);
        fetch(0, 32'b1101_000_000_000, 0);
        step();
        ack_v[0]   = 1'b1;
        rdata_v[0] = 32'b0001_001_010_011;
        for (int i = 0; i < 20; i++) begin
            check("halt_sticky", obs[0].hlt, 1);
            check("halt_noreq", obs[0].req, 0);
            step();
        end
        ack_v[0] = 1'b0;

        // PCW=2: address wrap, then reset during MEM of a LOAD
        switch_cfg(1);
        check("w_addr0", obs[1].addr, 0);
        for (int i = 0; i < 4; i++) begin
            fetch(1, 32'b0000_000_000_000, 0);
            step();
            check("wrap_addr", obs[1].addr, (i + 1) % 4);
        end
        fetch(1, 32'b1110_0100_00_100, 0);
        step();
        check("rst_mid_re", obs[1].re, 1);
        rst_v[1] = 1'b1;
        step();
        check("abort_req", obs[1].req, 1);
        check("abort_pc", obs[1].addr, 0);
        check("abort_re", obs[1].re, 0);
        check("abort_we", obs[1].we, 0);
        rst_v[1] = 1'b0;
        step();
        check("abort_pc2", obs[1].addr, 0);

        // OPW=5 REGW=4 ADDRW=6: ALU op 3, a=5, b=10, dest=12
        switch_cfg(2);
        fetch(2, 32'b00011_0101_1010_1100, 0);
        check("wide_dec_ra", obs[2].ra, 5);
        check("wide_dec_rb", obs[2].rb, 10);
        check("wide_dec_req", obs[2].req, 0);
        step();
        check("wide_ex_we", obs[2].we, 1);
        check("wide_ex_wa", obs[2].wa, 12);
        check("wide_ex_op", obs[2].alu, 3);
        step();
        check("wide_next_req", obs[2].req, 1);
        check("wide_next_addr", obs[2].addr, 1);
        step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cu_seq.md
# cu_seq

Multi-cycle, parametrised control unit and the successor to the combinational `cu` field decoder. It fetches instructions over a request/acknowledge handshake, holds them in an instruction register and steps through a FETCH/DECODE/EXEC/MEM/WB state machine. Each state drives register-file, ALU and data-memory control for exactly the cycles it needs. It sits between instruction memory and the datapath, and also owns the program counter, HALT and illegal-opcode detection.

## Interface
Parameters:
- `OPW`, 4: opcode width.
- `REGW`, 3: register index width.
- `ADDRW`, 4: data-memory address width; must satisfy ADDRW ≤ 2·REGW.
- `PCW`, 8: program counter width.
- `INSTW`, OPW+3·REGW (13): instruction width. Derived; never overridden.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PCW  fetch address (= pc).
- `imem_ack`  in  1  instruction valid this cycle.
- `imem_rdata`  in  INSTW  instruction word.
- `rf_ra`, `rf_rb`  out  REGW each  register-file read indices.
- `rf_wa`  out  REGW  write index.
- `rf_we`  out  1  register write enable.
- `rf_wsel`  out  1  write source: 0 = ALU, 1 = memory.
- `alu_op`  out  OPW  ALU operation (raw opcode).
- `dm_addr`  out  ADDRW  data-memory address.
- `dm_re`, `dm_we`  out  1 each  data-memory read/write strobes.
- `halted`  out  1  sticky halt flag.
- `illegal`  out  1  one-cycle pulse on an illegal opcode.

## Operation
- Field layout, MSB first:
  - R-type: opcode[INSTW-1 -: OPW], a[3·REGW-1 -: REGW], b[2·REGW-1 -: REGW], dest[REGW-1:0].
  - M-type: opcode, adrr[INSTW-OPW-1 -: ADDRW], dest[REGW-1:0]. Bits between adrr and dest are reserved and ignored.
- Opcode map (OPW=4):
  - 0000 NOP.
  - 0001–1001 ALU ops (R-type).
  - 1010–1100 illegal.
  - 1101 HALT.
  - 1110 LOAD: rf[dest] ← mem[adrr].
  - 1111 STORE: mem[adrr] ← rf[dest].
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - `imem_req`=1 and `imem_addr`=pc, held until `imem_ack`.
  - On ack: ir ← `imem_rdata`, pc ← pc+1 (wraps modulo 2^PCW), then DECODE.
- DECODE:
  - R-type: `rf_ra`=a, `rf_rb`=b.
  - LOAD/STORE: `rf_ra`=dest.
  - Next state: NOP → FETCH; illegal → FETCH with `illegal`=1; HALT → HALT; ALU → EXEC; LOAD/STORE → MEM.
- EXEC (ALU op): `alu_op`=opcode, `rf_ra`/`rf_rb` held, `rf_we`=1, `rf_wa`=dest, `rf_wsel`=0; then FETCH.
- MEM:
  - `dm_addr`=adrr.
  - LOAD: `dm_re`=1, then WB.
  - STORE: `dm_we`=1, `rf_ra`=dest held; then FETCH.
- WB (LOAD only): `rf_we`=1, `rf_wa`=dest, `rf_wsel`=1; then FETCH.
- HALT: `halted`=1; the unit stays in HALT until `rst`, and `imem_ack` is ignored.
- All outputs are Moore-style (state + ir). No output is combinationally dependent on `imem_ack`.

## Timing
- Reset values:
  - state=FETCH, pc=0, ir=0.
  - All strobes (`imem_req` excepted), `halted` and `illegal` = 0.
  - Index, address and `alu_op` outputs = 0.
  - `imem_req`=1 from the first cycle after reset release.
- Cycles from ack to the next `imem_req`:
  - NOP / illegal / HALT: 1 (DECODE only).
  - ALU: 2.
  - STORE: 2.
  - LOAD: 3.
- `rf_we`, `dm_re`, `dm_we` and `illegal` are each high for exactly one cycle per instruction.
- An ack arriving outside FETCH is ignored.
- `rst` asserted mid-instruction aborts it on that edge. No strobe is asserted in the following cycle, and pc returns to 0.
- pc = 2^PCW−1 fetches then wraps to 0; this is not an error.

## Structure
- `cu_pkg`:
  - `state_t` enum.
  - Opcode localparams (OP_NOP, OP_HALT, OP_LOAD, OP_STORE, ALU_MIN/ALU_MAX).
  - Field-slice functions parametrised on OPW/REGW/ADDRW.
- Sub-module `cu_decode`: combinational ir → {class, a, b, dest, adrr}. Instantiated once; the FSM consumes its outputs.

## Test plan
- Reset, then ack 0001_001_010_011 → DECODE `rf_ra`=1, `rf_rb`=2. EXEC `rf_we`=1, `rf_wa`=3, `alu_op`=0001. Next fetch `imem_addr`=1.
- LOAD 1110_0100_00_100 with ack delayed 3 cycles → `imem_req` held 4 cycles. MEM `dm_re`=1, `dm_addr`=4. WB `rf_we`=1, `rf_wa`=4, `rf_wsel`=1.
- STORE 1111_1100_00_101 → DECODE/MEM `rf_ra`=5. MEM `dm_we`=1, `dm_addr`=12. No `rf_we` at any point.
- Opcode 1011 → `illegal` pulses once, no other strobe, pc advances. Then HALT 1101 → `halted`=1 and stays 1 for 20 cycles despite `imem_ack`=1.
- PCW=2: four NOPs → `imem_addr` sequence 0,1,2,3,0. Assert `rst` during MEM of a LOAD → next cycle FETCH, pc=0, `dm_re`=0, `rf_we`=0.
- OPW=5, REGW=4, ADDRW=6 (INSTW=17): an ALU instruction decodes a/b/dest at the new field positions, with the same cycle counts as the default configuration.
